// File: rtl/enc_mult.sv
// Bit-serial SEC-DED encoder for (8,4), (16,11) and (32,26) codes.
// It takes one info bit per cycle, MSB first, and uses valid/ready handshakes.
module enc_mult #(
  parameter int MAX_CODEWORD_WIDTH = 32,
  parameter int MAX_INFO_WIDTH     = 26
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [MAX_INFO_WIDTH-1:0]     data_in,
  input  logic [1:0]                    mod,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [MAX_CODEWORD_WIDTH-1:0] data_out,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [1:0]                    dbg_state
);
  localparam int MAX_PARITY_WIDTH = MAX_CODEWORD_WIDTH - MAX_INFO_WIDTH;
  localparam int CNT_W            = $clog2(MAX_INFO_WIDTH);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  // in_ready is high only in IDLE; out_valid is high only in DONE. The two never overlap.
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t                          state, state_nxt;
  logic [MAX_INFO_WIDTH-1:0]       info_q, info_nxt;
  logic [1:0]                      mod_q, mod_nxt;
  logic [CNT_W-1:0]                cnt, cnt_nxt;
  logic [MAX_PARITY_WIDTH-2:0]     acc, acc_nxt;
  logic                            acc_all, all_nxt;
  logic [MAX_CODEWORD_WIDTH-1:0]   dout_q, dout_nxt, cw;
  logic                            cur_bit;
  logic [2:0]                      p_cur;
  logic [5:0]                      idx;
  logic [31:0]                     row_sh;

  function automatic logic [31:0] h_row(input logic [1:0] m, input int j);
    h_row = '0;
    case (m)
      2'b00: case (j)
        0: h_row = 32'h000000B1;  1: h_row = 32'h000000D2;
        2: h_row = 32'h000000E4;  3: h_row = 32'h000000FF;
        default: h_row = '0;
      endcase
      2'b01: case (j)
        0: h_row = 32'h0000AB61;  1: h_row = 32'h0000CDA2;
        2: h_row = 32'h0000F1C4;  3: h_row = 32'h0000FE08;
        4: h_row = 32'h0000FFFF;
        default: h_row = '0;
      endcase
      2'b10: case (j)
        0: h_row = 32'hAAAB56C1;  1: h_row = 32'hCCCD9B42;
        2: h_row = 32'hF0F1E384;  3: h_row = 32'hFF01FC08;
        4: h_row = 32'hFFFE0010;  5: h_row = 32'hFFFFFFFF;
        default: h_row = '0;
      endcase
      default: h_row = '0;
    endcase
  endfunction

  function automatic logic [2:0] p_of(input logic [1:0] m);
    case (m)
      2'b00:   p_of = 3'd4;
      2'b01:   p_of = 3'd5;
      default: p_of = 3'd6;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] k_m1(input logic [1:0] m);
    case (m)
      2'b00:   k_m1 = CNT_W'(3);
      2'b01:   k_m1 = CNT_W'(10);
      default: k_m1 = CNT_W'(25);
    endcase
  endfunction

  function automatic logic [MAX_INFO_WIDTH-1:0] k_mask(input logic [1:0] m);
    k_mask = '0;
    for (int i = 0; i < MAX_INFO_WIDTH; i++) k_mask[i] = (i <= int'(k_m1(m)));
  endfunction

  assign in_ready  = rst && (state == IDLE);
  assign out_valid = (state == DONE);
  assign data_out  = dout_q;
  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    info_nxt  = info_q;
    mod_nxt   = mod_q;
    cnt_nxt   = cnt;
    acc_nxt   = acc;
    all_nxt   = acc_all;
    dout_nxt  = dout_q;
    cur_bit   = info_q[cnt];
    p_cur     = p_of(mod_q);
    idx       = 6'(p_cur) + 6'(cnt);
    row_sh    = '0;
    cw        = '0;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          mod_nxt = mod;
          acc_nxt = '0;
          all_nxt = 1'b0;
          if (mod == 2'b11) begin
            info_nxt  = '0;
            cnt_nxt   = '0;
            dout_nxt  = '0;
            state_nxt = DONE;
          end else begin
            info_nxt  = data_in & k_mask(mod);
            cnt_nxt   = k_m1(mod);
            state_nxt = CALC;
          end
        end
      end
      CALC: begin
        // Only the P-1 Hamming rows are accumulated; the all-ones row is folded in at the end.
        for (int j = 0; j < MAX_PARITY_WIDTH - 1; j++) begin
          row_sh = h_row(mod_q, j) >> idx;
          if (j < int'(p_cur) - 1) acc_nxt[j] = acc[j] ^ (cur_bit & row_sh[0]);
        end
        all_nxt = acc_all ^ cur_bit;
        if (cnt == '0) begin
          cw = MAX_CODEWORD_WIDTH'(info_q) << p_cur;
          cw = cw | (MAX_CODEWORD_WIDTH'(all_nxt ^ (^acc_nxt)) << (p_cur - 3'd1));
          cw = cw | MAX_CODEWORD_WIDTH'(acc_nxt);
          dout_nxt  = cw;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      info_q  <= '0;
      mod_q   <= '0;
      cnt     <= '0;
      acc     <= '0;
      acc_all <= 1'b0;
      dout_q  <= '0;
    end else begin
      info_q  <= info_nxt;
      mod_q   <= mod_nxt;
      cnt     <= cnt_nxt;
      acc     <= acc_nxt;
      acc_all <= all_nxt;
      dout_q  <= dout_nxt;
    end
  end
endmodule

// File: doc/enc_mult.md
Name: enc_mult

Overview:
- Hamming/SEC-DED encoder: turns an info word into a codeword whose syndrome is all-zero under the team's three parity-check matrices.
- Selected by mod: (8,4), (16,11) or (32,26).
- Sits on the transmit side, opposite the syndrome/decoder path.
- Bit-serial: processes one info bit per cycle, with valid/ready handshakes on input and output.

Parameters:
- MAX_CODEWORD_WIDTH, 32, widest codeword N.
- MAX_INFO_WIDTH, 26, widest info word K.
- MAX_PARITY_WIDTH, localparam = MAX_CODEWORD_WIDTH - MAX_INFO_WIDTH (6), widest parity P.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- data_in  in  MAX_INFO_WIDTH  info word; only bits [K-1:0] are used.
- mod  in  2  code select: 00 (N8,K4,P4), 01 (N16,K11,P5), 10 (N32,K26,P6), 11 illegal.
- in_valid  in  1  data_in/mod are valid.
- in_ready  out  1  block can accept a word.
- data_out  out  MAX_CODEWORD_WIDTH  codeword, zero-padded above bit N-1.
- out_valid  out  1  data_out is valid.
- out_ready  in  1  consumer accepts data_out.

Behaviour:
- Codeword layout:
  - c[N-1:P] = info[K-1:0].
  - c[j] = p[j] for j < P-1; c[P-1] = overall parity.
- Parity-check rows (hex, bit N-1 leftmost):
  - mod00: r0=B1, r1=D2, r2=E4, r3=FF.
  - mod01: r0=AB61, r1=CDA2, r2=F1C4, r3=FE08, r4=FFFF.
  - mod10: r0=AAAB56C1, r1=CCCD9B42, r2=F0F1E384, r3=FF01FC08, r4=FFFE0010, r5=FFFFFFFF.
- Parity equations:
  - p[j] = XOR over i of info[i] & r_j[P+i], for j = 0..P-2.
  - c[P-1] = XOR(info) ^ XOR(p[P-2:0]).
  - Required property: r_j · c = 0 (mod 2) for every row.
- FSM: IDLE, CALC, DONE.
- IDLE:
  - in_ready = 1 (forced 0 while rst low).
  - On an edge with in_valid & in_ready: latch data_in[K-1:0] and mod, clear accumulators, load bit counter = K-1, go to CALC.
  - If mod == 11: go straight to DONE with data_out = 0.
- CALC:
  - in_ready = 0.
  - Each edge processes info bit i = counter, MSB first:
    - acc[j] ^= info[i] & r_j[P+i] for j < P-1.
    - acc_all ^= info[i].
    - Decrement counter.
  - On the edge processing i = 0: register data_out = {zero pad, info, final parity}, set out_valid = 1, go to DONE.
  - Latency: out_valid rises K edges after the acceptance edge (4/11/26). mod 11 takes 1 edge.
- DONE:
  - out_valid = 1; data_out held stable while out_ready = 0 (indefinite backpressure).
  - On an edge with out_valid & out_ready: out_valid <= 0, go to IDLE; data_out keeps its last value.
  - in_ready rises in the cycle after the output handshake; there is no input/output overlap.
- in_valid outside IDLE is ignored, and data_in/mod changes have no effect after acceptance. mod is sampled only at acceptance.
- Reset (asserted at any time, including mid-CALC or in DONE):
  - Immediately: state = IDLE, out_valid = 0, data_out = 0, counter and accumulators = 0.
  - The in-flight word is discarded.
  - After release, the first edge with in_valid & in_ready accepts a new word.
- Counter width is ceil(log2(MAX_INFO_WIDTH)). The counter never wraps: the transition on i = 0 is what terminates CALC.

Test Plan:
- mod=00, data_in=4'h8 -> out_valid 4 edges after accept, data_out=32'h00000087.
- mod=00, data_in=4'hF -> data_out=32'h000000FF. Also: data_in upper bits set (26'h3FFFFF0) yields 32'h00000000, proving bits above K are ignored.
- mod=01, data_in=11'h001 -> out_valid after 11 edges, data_out=32'h00000033. Hold out_ready=0 for 20 cycles: data_out/out_valid stable and in_ready=0. Then out_ready=1 -> IDLE, in_ready=1 next cycle.
- mod=10, data_in=26'h3FFFFFF -> out_valid after 26 edges, data_out=32'hFFFFFFFF.
- mod=11, any data -> out_valid after 1 edge, data_out=0.
- Reset mid-CALC (mod=10, drop rst at CALC cycle 10):
  - out_valid=0, data_out=0, in_ready=0 while low.
  - After release: mod=00, data 4'h8 gives 32'h00000087 with no residue from the aborted word.
- Random sweep: for each mod, check every H row · data_out = 0 on all outputs.
